// File: rtl/traffic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_pkg : lamp codes, controller state encoding and output decode  | rev 1.0
// ---------------------------------------------------------------------------
package traffic_pkg;

   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;
   localparam logic [1:0] OFF    = 2'b11;

   typedef enum logic [3:0] {
      ST_A_GREEN  = 4'd0,
      ST_A_YELLOW = 4'd1,
      ST_ALL_RED_1 = 4'd2,
      ST_B_GREEN  = 4'd3,
      ST_B_YELLOW = 4'd4,
      ST_ALL_RED_2 = 4'd5,
      ST_PED_WALK = 4'd6,
      ST_PED_FLASH = 4'd7,
      ST_NIGHT_ON = 4'd8,
      ST_NIGHT_OFF = 4'd9
   } state_t;

   // Returns {light_a, light_b, ped_light}; odd_sec selects the flashing-walk phase.
   function automatic logic [5:0] lamp_decode(input state_t st, input logic odd_sec);
      logic [5:0] lamps;
      lamps = {RED, RED, RED};
      case (st)
         ST_A_GREEN:   lamps = {GREEN, RED, RED};
         ST_A_YELLOW:  lamps = {YELLOW, RED, RED};
         ST_B_GREEN:   lamps = {RED, GREEN, RED};
         ST_B_YELLOW:  lamps = {RED, YELLOW, RED};
         ST_PED_WALK:  lamps = {RED, RED, GREEN};
         ST_PED_FLASH: lamps = {RED, RED, (odd_sec ? OFF : GREEN)};
         ST_NIGHT_ON:  lamps = {YELLOW, YELLOW, OFF};
         ST_NIGHT_OFF: lamps = {OFF, OFF, OFF};
         default:      lamps = {RED, RED, RED};
      endcase
      return lamps;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen : prescaler producing a 1-cycle pulse every TICKS_PER_SEC clocks  | rev 1.0
// ---------------------------------------------------------------------------
module tick_gen #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   output logic sec_tick_o
);

   localparam int CW = $clog2(TICKS_PER_SEC);

   logic [CW-1:0] cnt_q;

   assign sec_tick_o = (cnt_q == CW'(TICKS_PER_SEC - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i || sec_tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/traffic_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_fsm : A/B intersection controller with pedestrian phase and night flash  | rev 1.0
// ---------------------------------------------------------------------------
module traffic_fsm
   import traffic_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int T_GREEN       = 10,
   parameter int T_YELLOW      = 3,
   parameter int T_RED_CLEAR   = 1,
   parameter int T_PED         = 8,
   parameter int T_PED_FLASH   = 4,
   parameter int T_BLINK       = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req,
   input  logic       night_mode,
   output logic [1:0] light_a,
   output logic [1:0] light_b,
   output logic [1:0] ped_light,
   output logic       ped_waiting
);

   state_t     state_q, state_d;
   logic [7:0] sec_cnt_q, sec_cnt_d;
   logic       ped_waiting_q, ped_waiting_d;
   logic [5:0] lamps_q, lamps_d;
   logic [7:0] dwell;
   logic       sec_tick;
   logic       expire;

   tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_tick_gen (
      .clk_i      (clk),
      .rst_i      (reset),
      .clear_i    (expire),
      .sec_tick_o (sec_tick)
   );

   always_comb begin
      dwell = 8'(T_RED_CLEAR);
      case (state_q)
         ST_A_GREEN, ST_B_GREEN:    dwell = 8'(T_GREEN);
         ST_A_YELLOW, ST_B_YELLOW:  dwell = 8'(T_YELLOW);
         ST_PED_WALK:               dwell = 8'(T_PED);
         ST_PED_FLASH:              dwell = 8'(T_PED_FLASH);
         ST_NIGHT_ON, ST_NIGHT_OFF: dwell = 8'(T_BLINK);
         default:                   dwell = 8'(T_RED_CLEAR);
      endcase

      expire = sec_tick && (sec_cnt_q == dwell - 8'd1);

      state_d = state_q;
      if (expire) begin
         case (state_q)
            ST_A_GREEN:   state_d = ST_A_YELLOW;
            ST_A_YELLOW:  state_d = ST_ALL_RED_1;
            ST_ALL_RED_1: state_d = night_mode ? ST_NIGHT_ON : ST_B_GREEN;
            ST_B_GREEN:   state_d = ST_B_YELLOW;
            ST_B_YELLOW:  state_d = ST_ALL_RED_2;
            // Night wins over a waiting pedestrian; the request is kept for later.
            ST_ALL_RED_2: state_d = night_mode    ? ST_NIGHT_ON :
                                    ped_waiting_q ? ST_PED_WALK : ST_A_GREEN;
            ST_PED_WALK:  state_d = ST_PED_FLASH;
            ST_PED_FLASH: state_d = ST_A_GREEN;
            ST_NIGHT_ON:  state_d = ST_NIGHT_OFF;
            ST_NIGHT_OFF: state_d = night_mode ? ST_NIGHT_ON : ST_ALL_RED_2;
            default:      state_d = ST_ALL_RED_2;
         endcase
      end

      if (expire) begin
         sec_cnt_d = 8'd0;
      end else if (sec_tick) begin
         sec_cnt_d = sec_cnt_q + 8'd1;
      end else begin
         sec_cnt_d = sec_cnt_q;
      end

      ped_waiting_d = ped_waiting_q;
      if (expire && (state_d == ST_PED_WALK)) begin
         ped_waiting_d = 1'b0;
      end else if (ped_req && (state_q != ST_PED_WALK) && (state_q != ST_PED_FLASH)) begin
         ped_waiting_d = 1'b1;
      end

      // Decoding the next state keeps outputs aligned with the state register.
      lamps_d = lamp_decode(state_d, sec_cnt_d[0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_ALL_RED_2;
         sec_cnt_q     <= 8'd0;
         ped_waiting_q <= 1'b0;
         lamps_q       <= {RED, RED, RED};
      end else begin
         state_q       <= state_d;
         sec_cnt_q     <= sec_cnt_d;
         ped_waiting_q <= ped_waiting_d;
         lamps_q       <= lamps_d;
      end
   end

   assign light_a     = lamps_q[5:4];
   assign light_b     = lamps_q[3:2];
   assign ped_light   = lamps_q[1:0];
   assign ped_waiting = ped_waiting_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_fsm : directed stimulus with queued per-cycle expectations  | rev 1.0
// ---------------------------------------------------------------------------
module tb_traffic_fsm;

   localparam logic [1:0] R = 2'b00;
   localparam logic [1:0] Y = 2'b01;
   localparam logic [1:0] G = 2'b10;
   localparam logic [1:0] O = 2'b11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ped_req = 1'b0;
   logic       night_mode = 1'b0;
   logic [1:0] light_a, light_b, ped_light;
   logic       ped_waiting;

   logic [6:0] sb[$];
   int         n_vec = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   traffic_fsm #(
      .TICKS_PER_SEC(4),
      .T_GREEN      (3),
      .T_YELLOW     (2),
      .T_RED_CLEAR  (1),
      .T_PED        (2),
      .T_PED_FLASH  (2),
      .T_BLINK      (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ped_req    (ped_req),
      .night_mode (night_mode),
      .light_a    (light_a),
      .light_b    (light_b),
      .ped_light  (ped_light),
      .ped_waiting(ped_waiting)
   );

   // Monitor: each cycle that has a queued expectation, compare mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         logic [6:0] exp_v;
         exp_v = sb.pop_front();
         n_vec++;
         if ({light_a, light_b, ped_light, ped_waiting} !== exp_v) begin
            n_err++;
            $display("FAIL vec%0d @%0t: got a=%b b=%b ped=%b pw=%b, expected a=%b b=%b ped=%b pw=%b",
                     n_vec, $time, light_a, light_b, ped_light, ped_waiting,
                     exp_v[6:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
         end
      end
   end

   // Expectation is for the outputs after the edge just taken; inputs apply to the next edge.
   task automatic step(input logic rst, input logic req, input logic ngt,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] p,
                       input logic pw);
      @(posedge clk);
      #1;
      sb.push_back({a, b, p, pw});
      reset      = rst;
      ped_req    = req;
      night_mode = ngt;
   endtask

   task automatic seg(input int n, input logic req, input logic ngt,
                      input logic [1:0] a, input logic [1:0] b, input logic [1:0] p,
                      input logic pw);
      for (int i = 0; i < n; i++) step(1'b0, req, ngt, a, b, p, pw);
   endtask

   // A_YELLOW through ALL_RED_2 with no night request.
   task automatic rest(input logic pw, input logic req);
      seg(8,  req, 1'b0, Y, R, R, pw);
      seg(4,  req, 1'b0, R, R, R, pw);
      seg(12, req, 1'b0, R, G, R, pw);
      seg(8,  req, 1'b0, R, Y, R, pw);
      seg(4,  req, 1'b0, R, R, R, pw);
   endtask

   task automatic ped_serve(input logic req);
      seg(8, req, 1'b0, R, R, G, 1'b0);
      seg(4, req, 1'b0, R, R, G, 1'b0);
      seg(4, req, 1'b0, R, R, O, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and plain A/B cycle
      step(1'b0, 1'b0, 1'b0, R, R, R, 1'b0);
      seg(3, 1'b0, 1'b0, R, R, R, 1'b0);
      seg(12, 1'b0, 1'b0, G, R, R, 1'b0);
      rest(1'b0, 1'b0);

      // Single-cycle pedestrian press in A_GREEN
      seg(1, 1'b1, 1'b0, G, R, R, 1'b0);
      seg(11, 1'b0, 1'b0, G, R, R, 1'b1);
      rest(1'b1, 1'b0);
      ped_serve(1'b0);

      // Night raised mid B_GREEN takes effect at ALL_RED_2 expiry
      seg(12, 1'b0, 1'b0, G, R, R, 1'b0);
      seg(8,  1'b0, 1'b0, Y, R, R, 1'b0);
      seg(4,  1'b0, 1'b0, R, R, R, 1'b0);
      seg(6,  1'b0, 1'b0, R, G, R, 1'b0);
      seg(6,  1'b0, 1'b1, R, G, R, 1'b0);
      seg(8,  1'b0, 1'b1, R, Y, R, 1'b0);
      seg(4,  1'b0, 1'b1, R, R, R, 1'b0);
      seg(4,  1'b0, 1'b1, Y, Y, O, 1'b0);
      seg(4,  1'b0, 1'b1, O, O, O, 1'b0);

      // Press plus night drop during NIGHT_ON
      step(1'b0, 1'b0, 1'b1, Y, Y, O, 1'b0);
      step(1'b0, 1'b1, 1'b0, Y, Y, O, 1'b0);
      seg(2, 1'b0, 1'b0, Y, Y, O, 1'b1);
      seg(4, 1'b0, 1'b0, O, O, O, 1'b1);
      seg(4, 1'b0, 1'b0, R, R, R, 1'b1);
      ped_serve(1'b0);

      // Button held: one pedestrian phase, request re-latches after it
      seg(1, 1'b1, 1'b0, G, R, R, 1'b0);
      seg(11, 1'b1, 1'b0, G, R, R, 1'b1);
      rest(1'b1, 1'b1);
      ped_serve(1'b1);
      seg(1, 1'b1, 1'b0, G, R, R, 1'b0);
      seg(11, 1'b0, 1'b0, G, R, R, 1'b1);
      rest(1'b1, 1'b0);

      // Reset mid PED_WALK
      seg(3, 1'b0, 1'b0, R, R, G, 1'b0);
      step(1'b1, 1'b0, 1'b0, R, R, G, 1'b0);
      step(1'b0, 1'b0, 1'b0, R, R, R, 1'b0);
      seg(3, 1'b0, 1'b0, R, R, R, 1'b0);
      seg(4, 1'b0, 1'b0, G, R, R, 1'b0);

      @(negedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
